// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg
//   Shared definitions for the register-file read arbiter:
//   - FSM state encodings (IDLE / ACCESS / RESPOND)
//   - idx_w(): index width for a NUM_REQ-entry requester vector
package regfile_arb_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;

  // Never returns 0, so a 2-requester build still gets a 1-bit index.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker
//   Combinational round-robin search. Priority starts at ptr_i+1 and
//   wraps modulo NUM_REQ, so the requester at ptr_i is considered last.
// Ports:
//   req_i  [NUM_REQ]  request vector
//   ptr_i  [IW]       index of the most recently granted requester
//   gnt_o  [NUM_REQ]  one-hot grant (all zero when nothing is requesting)
//   idx_o  [IW]       index of the granted requester
//   any_o             at least one request present
module rr_priority_picker
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (int'(ptr_i) + k) % NUM_REQ;
      if (!any_o && req_i[c[IW-1:0]]) begin
        any_o             = 1'b1;
        idx_o             = c[IW-1:0];
        gnt_o[c[IW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter
//   Shares one register-file read port between NUM_REQ requesters with
//   round-robin fairness and a single outstanding transaction.
//   Flow: IDLE (accept) -> ACCESS (one read cycle) -> RESPOND (hold until
//   the granted requester takes the response) -> IDLE.
// Ports:
//   clock_i, reset_i        clock, synchronous active-high reset
//   req_valid_i/req_ready_o request handshake, ready one-hot in IDLE only
//   req_addr_i              linearised per-requester addresses
//   rf_read_en_o/_addr_o    read port towards the register-file mux tree
//   rf_read_data_i          combinational read data from the register file
//   resp_valid_o/resp_ready_i response handshake, valid one-hot
//   resp_data_o             registered read data
// Optional build macro:
//   REGFILE_ARB_X0_BYPASS_EN  address-0 reads skip the port and return 0
//                             one cycle earlier.
module regfile_read_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_SIZE = 5,
  parameter int DATA_SIZE = 64
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic                           rf_read_en_o,
  output logic [ADDR_SIZE-1:0]           rf_read_addr_o,
  input  logic [DATA_SIZE-1:0]           rf_read_data_i,
  output logic [NUM_REQ-1:0]             resp_valid_o,
  output logic [DATA_SIZE-1:0]           resp_data_o,
  input  logic [NUM_REQ-1:0]             resp_ready_i
);

  localparam int IW = idx_w(NUM_REQ);

  logic [1:0]                          state_q, state_d;
  logic [IW-1:0]                       rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]                       grant_q, grant_d;
  logic [ADDR_SIZE-1:0]                addr_q, addr_d;
  logic [DATA_SIZE-1:0]                data_q, data_d;

  logic [NUM_REQ-1:0][ADDR_SIZE-1:0]   addr_arr;
  logic [NUM_REQ-1:0]                  pick_gnt;
  logic [IW-1:0]                       pick_idx;
  logic                                pick_any;

  assign addr_arr = req_addr_i;

  rr_priority_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Ready only points at a valid requester, so any_o in IDLE is acceptance.
  assign req_ready_o    = (state_q == ST_IDLE) ? pick_gnt : '0;
  assign rf_read_en_o   = (state_q == ST_ACCESS);
  assign rf_read_addr_o = addr_q;
  assign resp_data_o    = data_q;

  always_comb begin
    resp_valid_o = '0;
    if (state_q == ST_RESPOND) resp_valid_o[grant_q] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    data_d   = data_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d  = pick_idx;
          addr_d   = addr_arr[pick_idx];
          rr_ptr_d = pick_idx;
          state_d  = ST_ACCESS;
`ifdef REGFILE_ARB_X0_BYPASS_EN
          if (addr_arr[pick_idx] == '0) begin
            data_d  = '0;
            state_d = ST_RESPOND;
          end
`endif
        end
      end
      ST_ACCESS: begin
        data_d  = rf_read_data_i;
        state_d = ST_RESPOND;
      end
      ST_RESPOND: begin
        if (resp_ready_i[grant_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= IW'(NUM_REQ - 1);
      grant_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

endmodule
